// File: rtl/dec_latch_pkg.sv
// Shared types for the addressable latch: per-channel operating mode and its decode
// from the active-low enable/clear pair.
package dec_latch_pkg;

    typedef enum logic [1:0] {
        MODE_LATCH = 2'd0,
        MODE_HOLD  = 2'd1,
        MODE_DEMUX = 2'd2,
        MODE_CLEAR = 2'd3
    } dl_mode_t;

    // g and clr are both active-low; clr low without g low clears the whole channel
    function automatic dl_mode_t dl_mode(input logic g, input logic clr);
        dl_mode_t m;
        case ({g, clr})
            2'b01:   m = MODE_LATCH;
            2'b11:   m = MODE_HOLD;
            2'b00:   m = MODE_DEMUX;
            2'b10:   m = MODE_CLEAR;
            default: m = MODE_HOLD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dec_latch_n_if.sv
// Select/data/control bus and latched outputs of dec_latch_n.
// Optional readback line rb exists only when ADLATCH_READBACK_EN is defined.
interface dec_latch_n_if #(
    parameter int SEL_W    = 3,
    parameter int CHANNELS = 2
);
    localparam int OUTS = 2 ** SEL_W;

    logic [SEL_W-1:0]         sel;
    logic [CHANNELS-1:0]      d;
    logic [CHANNELS-1:0]      g;
    logic [CHANNELS-1:0]      clr;
    logic [CHANNELS*OUTS-1:0] q;
`ifdef ADLATCH_READBACK_EN
    logic [CHANNELS-1:0]      rb;
`endif

    modport master (
        output sel, d, g, clr,
`ifdef ADLATCH_READBACK_EN
        input  rb,
`endif
        input  q
    );

    modport slave (
        input  sel, d, g, clr,
`ifdef ADLATCH_READBACK_EN
        output rb,
`endif
        output q
    );

endinterface

// File: rtl/dec_latch_chan.sv
// One channel of the addressable latch: 2**SEL_W-bit register with LATCH/HOLD/DEMUX/CLEAR
// modes and, with ADLATCH_READBACK_EN, a registered copy of the addressed bit.
module dec_latch_chan
    import dec_latch_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    d,
    input  logic                    g,
    input  logic                    clr,
`ifdef ADLATCH_READBACK_EN
    output logic                    rb,
`endif
    output logic [(2**SEL_W)-1:0]   q
);
    localparam int OUTS = 2 ** SEL_W;

    dl_mode_t          mode_s;
    logic [OUTS-1:0]   q_next_s;
    logic [OUTS-1:0]   q_r;

    // Mode decode and next-state of the channel register
    always_comb begin
        mode_s   = dl_mode(g, clr);
        q_next_s = q_r;
        case (mode_s)
            MODE_LATCH: q_next_s[sel] = d;
            MODE_HOLD:  q_next_s = q_r;
            MODE_DEMUX: begin
                q_next_s      = {OUTS{1'b0}};
                q_next_s[sel] = d;
            end
            MODE_CLEAR: q_next_s = {OUTS{1'b0}};
            default:    q_next_s = q_r;
        endcase
    end

    // Channel register; reset wins over every mode
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {OUTS{1'b0}};
        end else begin
            q_r <= q_next_s;
        end
    end

    assign q = q_r;

`ifdef ADLATCH_READBACK_EN
    logic rb_r;

    // Readback samples the addressed bit of the value being written this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_r <= 1'b0;
        end else begin
            rb_r <= q_next_s[sel];
        end
    end

    assign rb = rb_r;
`endif

endmodule

// File: rtl/dec_latch_n.sv
// CHANNELS-wide addressable latch / 1-of-2**SEL_W demultiplexer sharing one select bus.
// Define ADLATCH_READBACK_EN to add the registered per-channel readback bit rb.
module dec_latch_n
    import dec_latch_pkg::*;
#(
    parameter int SEL_W    = 3,
    parameter int CHANNELS = 2
) (
    input  logic          clk,
    input  logic          rst,
    dec_latch_n_if.slave  bus
);
    localparam int OUTS = 2 ** SEL_W;

    wire [CHANNELS*OUTS-1:0] q_s;
`ifdef ADLATCH_READBACK_EN
    wire [CHANNELS-1:0]      rb_s;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        dec_latch_chan #(
            .SEL_W (SEL_W)
        ) u_chan (
            .clk (clk),
            .rst (rst),
            .sel (bus.sel),
            .d   (bus.d[c]),
            .g   (bus.g[c]),
            .clr (bus.clr[c]),
`ifdef ADLATCH_READBACK_EN
            .rb  (rb_s[c]),
`endif
            .q   (q_s[c*OUTS +: OUTS])
        );
    end

    assign bus.q = q_s;
`ifdef ADLATCH_READBACK_EN
    assign bus.rb = rb_s;
`endif

endmodule
